// File: rtl/playfield_store.sv
// Tetris playfield: occupancy grid with piece lock, collision query and
// a one-row-per-cycle scan that collapses full rows after every lock.
module playfield_store #(
  parameter int COLS = 10,
  parameter int ROWS = 20,
  parameter int XW   = 5,
  parameter int YW   = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lock_req,
  input  logic [4*XW-1:0] lock_x,
  input  logic [4*YW-1:0] lock_y,
  input  logic [4*XW-1:0] q_x,
  input  logic [4*YW-1:0] q_y,
  output logic            collide,
  output logic            busy,
  output logic            done,
  output logic [2:0]      lines_cleared,
  output logic            top_out,
  input  logic [YW-1:0]   rd_row,
  output logic [COLS-1:0] rd_data
);

  localparam int RW = $clog2(ROWS);
  localparam int XP = 2 ** XW;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [COLS-1:0] grid_reg  [ROWS];
  logic [COLS-1:0] grid_next [ROWS];
  logic [RW-1:0]   r_reg, r_next;
  logic [2:0]      cnt_reg, cnt_next;
  logic [2:0]      lines_reg, lines_next;
  logic            top_reg, top_next;

  logic [3:0]      lock_ok, lock_high, q_bad;
  logic [COLS-1:0] lock_mask [4];
  logic [YW-1:0]   lock_yc   [4];
  logic [COLS-1:0] row_cur;
  logic            row_full;

  // Per-cell decode for both the lock piece and the query piece.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cell
      logic [XW-1:0]   lx, qx;
      logic [YW-1:0]   ly, qy;
      logic [XP-1:0]   lock_onehot, q_onehot;
      logic [COLS-1:0] q_row;
      logic            q_in;

      assign lx = lock_x[gi*XW +: XW];
      assign ly = lock_y[gi*YW +: YW];
      assign qx = q_x[gi*XW +: XW];
      assign qy = q_y[gi*YW +: YW];

      assign lock_onehot   = XP'(1) << lx;
      assign lock_mask[gi] = lock_onehot[COLS-1:0];
      assign lock_yc[gi]   = ly;
      assign lock_ok[gi]   = !ly[YW-1] && (ly < YW'(ROWS)) && (lx < XW'(COLS));
      assign lock_high[gi] = !ly[YW-1] && (ly >= YW'(ROWS));

      always_comb begin
        q_row = '0;
        for (int rr = 0; rr < ROWS; rr++)
          if (qy == YW'(rr)) q_row = grid_reg[rr];
      end

      assign q_onehot  = XP'(1) << qx;
      assign q_in      = !qy[YW-1] && (qy < YW'(ROWS)) && (qx < XW'(COLS));
      // Walls and floor always collide; the spawn area above the field never does.
      assign q_bad[gi] = (qx >= XW'(COLS)) || qy[YW-1] ||
                         (q_in && |(q_row & q_onehot[COLS-1:0]));
    end
  endgenerate

  always_comb begin
    row_cur = '0;
    for (int rr = 0; rr < ROWS; rr++)
      if (r_reg == RW'(rr)) row_cur = grid_reg[rr];
  end
  assign row_full = &row_cur;

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    cnt_next   = cnt_reg;
    lines_next = lines_reg;
    top_next   = top_reg;
    for (int rr = 0; rr < ROWS; rr++) grid_next[rr] = grid_reg[rr];

    case (state_reg)
      IDLE: begin
        if (lock_req) begin
          for (int i = 0; i < 4; i++)
            for (int rr = 0; rr < ROWS; rr++)
              if (lock_ok[i] && (lock_yc[i] == YW'(rr)))
                grid_next[rr] = grid_next[rr] | lock_mask[i];
          top_next   = top_reg | (|lock_high);
          cnt_next   = '0;
          r_next     = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          // Pointer stays put so the row that dropped in gets examined next.
          for (int rr = 0; rr < ROWS - 1; rr++)
            if (rr >= int'(r_reg)) grid_next[rr] = grid_reg[rr+1];
          grid_next[ROWS-1] = '0;
          cnt_next          = cnt_reg + 3'd1;
        end else if (r_reg == RW'(ROWS - 1)) begin
          lines_next = cnt_reg;
          state_next = DONE;
        end else begin
          r_next = r_reg + RW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      cnt_reg   <= '0;
      lines_reg <= '0;
      top_reg   <= 1'b0;
      for (int rr = 0; rr < ROWS; rr++) grid_reg[rr] <= '0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
      lines_reg <= lines_next;
      top_reg   <= top_next;
      for (int rr = 0; rr < ROWS; rr++) grid_reg[rr] <= grid_next[rr];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int rr = 0; rr < ROWS; rr++)
      if (rd_row == YW'(rr)) rd_data = grid_reg[rr];
  end

  assign busy          = (state_reg != IDLE);
  assign done          = (state_reg == DONE);
  assign collide       = busy || (|q_bad);
  assign lines_cleared = lines_reg;
  assign top_out       = top_reg;

endmodule

// File: doc/playfield_store.md
# playfield_store

Parametrised Tetris playfield memory: holds a ROWS×COLS occupancy grid, locks a four-cell piece into it, and answers combinational collision queries for a candidate piece position. After each lock it runs a sequential scan-and-collapse. Every full row is removed, the rows above shift down, and the number of cleared lines is reported. It sits between the piece controller (lock/query) and the renderer (row read port).

## Interface

Parameters:
- COLS, 10, playfield width in cells (≥4).
- ROWS, 20, playfield height in cells; row 0 is the bottom.
- XW, 5, column coordinate width (unsigned; 2^XW > COLS).
- YW, 6, row coordinate width (two's complement; 2^(YW-1) > ROWS).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- lock_req  in  1  request to write the piece in lock_x/lock_y into the grid; sampled only in IDLE.
- lock_x  in  4*XW  piece cell columns; cell i at [i*XW +: XW].
- lock_y  in  4*YW  piece cell rows, signed; cell i at [i*YW +: YW].
- q_x  in  4*XW  query cell columns, same packing.
- q_y  in  4*YW  query cell rows, signed, same packing.
- collide  out  1  combinational: query overlaps an occupied cell, a wall, or the floor.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when the scan/collapse finishes.
- lines_cleared  out  3  rows removed by the last lock; valid from done onward.
- top_out  out  1  sticky: a locked cell was at y ≥ ROWS (game over).
- rd_row  in  YW  renderer row select (unsigned interpretation).
- rd_data  out  COLS  combinational row contents; 0 when rd_row ≥ ROWS.

## Operation

- States: IDLE, SCAN, DONE. A scan pointer r (row index) and a clear counter cnt are kept.
- IDLE with lock_req=1, on the sampling edge:
  - each cell i with 0 ≤ y_i < ROWS and x_i < COLS sets grid[y_i][x_i] = 1;
  - cells with x_i ≥ COLS or y_i < 0 are dropped silently;
  - any cell with y_i ≥ ROWS sets top_out and is not written;
  - cnt ← 0, r ← 0, state ← SCAN.
- Duplicate cells are idempotent.
- SCAN, one row per cycle:
  - If grid[r] is all ones: rows r..ROWS-2 take the contents of the row above, row ROWS-1 ← 0, cnt ← cnt+1, and r is unchanged (the row is re-examined).
  - Otherwise, if r = ROWS-1, state ← DONE; else r ← r+1.
- DONE: done=1 and lines_cleared ← cnt, then state ← IDLE.
- lines_cleared holds its value until the DONE state of the next lock.
- lock_req is ignored while busy; there is no queueing, and the controller must wait for done.
- collide is the OR over the 4 query cells of:
  - q_x ≥ COLS;
  - q_y < 0;
  - 0 ≤ q_y < ROWS and grid[q_y][q_x] = 1.
- Cells with q_y ≥ ROWS never collide on their own (spawn area above the field).
- collide is forced to 1 while busy.
- top_out clears only on reset.
- Reset mid-scan aborts the operation: grid is all zero, state IDLE, r=0, cnt=0.

## Timing

- Reset values: collide reflects the empty grid (walls/floor only), busy=0, done=0, lines_cleared=0, top_out=0, rd_data=0.
- Lock write takes effect at the accepting edge, so the grid is visible on rd_data the next cycle.
- busy rises the cycle after the accepting edge. If k rows are cleared, done is high exactly ROWS+k+1 cycles after the accepting edge, for one cycle; busy falls in the same cycle done falls.
- Each collapse takes one cycle. Maximum latency is ROWS+5 cycles, since k ≤ 4.
- collide and rd_data are purely combinational from grid and their inputs. During SCAN, rd_data shows intermediate collapse states.
- lines_cleared width is 3 bits; cnt never exceeds 4.

## Test plan

- Reset, then query cells (0,0),(1,0),(2,0),(3,0): collide=0. Shift the query to q_y=-1: collide=1. Query q_x=10: collide=1.
- Lock an I-piece at y=0, x=0..3: done after 21 cycles, lines_cleared=0, rd_data(0)=0x00F. Re-query the same cells: collide=1.
- Pre-fill row 0 x=0..5 with locks, then lock cells (6..9,0): done 22 cycles after accept, lines_cleared=1, row 0 = 0. Any row above is moved down one row.
- Build rows 0–3 full except column 9, with a marker at (0,4). Lock a vertical I at x=9, y=0..3: lines_cleared=4, done 25 cycles after accept, marker now at (0,0), rows 1–19 = 0.
- Lock cells with y=20,21 (rest valid): top_out=1 and stays 1 across later locks; the y ≥ 20 cells are not written.
- Assert lock_req during SCAN: it is ignored and the grid is unchanged by it. Assert reset mid-SCAN: the grid clears immediately, busy=0, done never pulses.
